// File: rtl/uart_responder_pkg.sv
// Shared definitions for uart_responder: state encoding, command field layout,
// register map constants and default response bytes.
package uart_responder_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_DATA = 2'd1;
  localparam state_t ST_RESP = 2'd2;

  localparam int unsigned WR_BIT  = 7;
  localparam int unsigned RSV_MSB = 6;
  localparam int unsigned RSV_LSB = 4;
  localparam int unsigned ADDR_W  = 4;

  localparam logic [ADDR_W-1:0] GPI_ADDR = 4'hF;

  localparam int unsigned TIMEOUT_DEF = 25000;
  localparam logic [7:0]  ACK_DEF     = 8'h06;
  localparam logic [7:0]  NAK_DEF     = 8'h15;

  function automatic logic cmd_legal(input logic [7:0] cmd);
    return cmd[RSV_MSB:RSV_LSB] == '0;
  endfunction

endpackage

// File: rtl/uart_responder_regs.sv
// 15x8 register file for uart_responder: one synchronous write port, one
// combinational read port with address 15 mapped to gpi, register 0 tapped to gpo.
module uart_responder_regs
  import uart_responder_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [7:0]        i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [7:0]        o_rdata,
  input  logic [7:0]        i_gpi,
  output logic [7:0]        o_gpo
);

  logic [7:0] r_mem [0:14];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 15; i++) r_mem[i] <= '0;
    end else if (i_we && (i_waddr != GPI_ADDR)) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  always_comb begin
    o_rdata = i_gpi;
    if (i_raddr != GPI_ADDR) o_rdata = r_mem[i_raddr];
  end

  assign o_gpo = r_mem[0];

endmodule

// File: rtl/uart_responder.sv
// Byte-level read/write command responder between UART receive and transmit.
// Define UART_RESPONDER_WRACK_EN to answer accepted writes with ACK; otherwise writes are silent.
module uart_responder
  import uart_responder_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF,
  parameter logic [7:0]  NAK     = NAK_DEF
`ifdef UART_RESPONDER_WRACK_EN
  ,
  parameter logic [7:0]  ACK     = ACK_DEF
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_stb,
  input  logic [7:0] rx_dat,
  input  logic       rx_err,
  output logic       rx_rdy,
  output logic       tx_stb,
  output logic [7:0] tx_dat,
  input  logic       tx_rdy,
  input  logic [7:0] gpi,
  output logic [7:0] gpo
);

  localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t            r_state;
  state_t            w_nxt;
  logic              r_rx_rdy;
  logic              r_tx_stb;
  logic [7:0]        r_tx_dat;
  logic [7:0]        w_tx_dat;
  logic [ADDR_W-1:0] r_addr;
  logic [CW-1:0]     r_cnt;
  logic              w_we;
  logic [7:0]        w_rdata;
  logic              w_rx_acc;
  logic              w_tx_acc;
  logic              w_cnt_done;

  // A byte flagged with a framing error is never accepted.
  assign w_rx_acc   = rx_stb & r_rx_rdy & ~rx_err;
  assign w_tx_acc   = r_tx_stb & tx_rdy;
  assign w_cnt_done = (r_cnt == CNT_LAST);

  always_comb begin
    w_nxt    = r_state;
    w_tx_dat = r_tx_dat;
    w_we     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_rx_acc) begin
          if (!cmd_legal(rx_dat)) begin
            w_nxt    = ST_RESP;
            w_tx_dat = NAK;
          end else if (rx_dat[WR_BIT]) begin
            w_nxt = ST_DATA;
          end else begin
            w_nxt    = ST_RESP;
            w_tx_dat = w_rdata;
          end
        end
      end
      ST_DATA: begin
        // Accepted data beats the timeout on the same cycle.
        if (w_rx_acc) begin
          w_we = 1'b1;
`ifdef UART_RESPONDER_WRACK_EN
          w_nxt    = ST_RESP;
          w_tx_dat = ACK;
`else
          w_nxt = ST_IDLE;
`endif
        end else if (rx_err || w_cnt_done) begin
          w_nxt = ST_IDLE;
        end
      end
      ST_RESP: begin
        if (w_tx_acc) w_nxt = ST_IDLE;
      end
      default: w_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_rx_rdy <= 1'b0;
      r_tx_stb <= 1'b0;
      r_tx_dat <= '0;
      r_addr   <= '0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_nxt;
      r_rx_rdy <= (w_nxt != ST_RESP);
      r_tx_stb <= (w_nxt == ST_RESP);
      r_tx_dat <= w_tx_dat;
      if ((r_state == ST_IDLE) && w_rx_acc) begin
        r_addr <= rx_dat[ADDR_W-1:0];
        r_cnt  <= '0;
      end else if ((r_state == ST_DATA) && !w_cnt_done) begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  uart_responder_regs u_regs (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_we),
    .i_waddr (r_addr),
    .i_wdata (rx_dat),
    .i_raddr (rx_dat[ADDR_W-1:0]),
    .o_rdata (w_rdata),
    .i_gpi   (gpi),
    .o_gpo   (gpo)
  );

  assign rx_rdy = r_rx_rdy;
  assign tx_stb = r_tx_stb;
  assign tx_dat = r_tx_dat;

endmodule

// File: tb/tb_uart_responder.sv
// Directed bench for uart_responder: a transaction table plus hand-written
// sequences for response hold, timeout boundary, error abort and async reset.
module tb_uart_responder;

  localparam int unsigned TB_TO = 20;

  logic       clk;
  logic       rst_n;
  logic       rx_stb;
  logic [7:0] rx_dat;
  logic       rx_err;
  logic       rx_rdy;
  logic       tx_stb;
  logic [7:0] tx_dat;
  logic       tx_rdy;
  logic [7:0] gpi;
  logic [7:0] gpo;

  int n_tests = 0;
  int n_fail  = 0;

  uart_responder #(.TIMEOUT(TB_TO)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .rx_stb (rx_stb),
    .rx_dat (rx_dat),
    .rx_err (rx_err),
    .rx_rdy (rx_rdy),
    .tx_stb (tx_stb),
    .tx_dat (tx_dat),
    .tx_rdy (tx_rdy),
    .gpi    (gpi),
    .gpo    (gpo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic       two;
    logic [7:0] cmd;
    logic [7:0] data;
    logic [7:0] gpi;
    logic [7:0] exp_tx;
    logic [7:0] exp_gpo;
  } vec_t;

  vec_t vecs[$];

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the byte was taken.
  task automatic send_byte(input logic [7:0] b);
    int w = 0;
    while (!rx_rdy && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!rx_rdy) begin
      chk1("rx_rdy_wait", rx_rdy, 1'b1);
      return;
    end
    rx_stb = 1'b1;
    rx_dat = b;
    @(posedge clk);
    @(negedge clk);
    rx_stb = 1'b0;
  endtask

  task automatic expect_resp(input string nm, input logic [7:0] exp);
    chk1({nm, "_stb"}, tx_stb, 1'b1);
    chk8({nm, "_dat"}, tx_dat, exp);
    chk1({nm, "_rxrdy"}, rx_rdy, 1'b0);
    tx_rdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tx_rdy = 1'b0;
    chk1({nm, "_done"}, tx_stb, 1'b0);
  endtask

  task automatic expect_none(input string nm);
    chk1({nm, "_nostb"}, tx_stb, 1'b0);
  endtask

  task automatic write_ack(input string nm);
`ifdef UART_RESPONDER_WRACK_EN
    expect_resp(nm, 8'h06);
`else
    expect_none(nm);
`endif
  endtask

  initial begin
    //            two  cmd    data   gpi    exp_tx exp_gpo
    vecs.push_back('{1'b1, 8'h80, 8'hA5, 8'h00, 8'h00, 8'hA5});
    vecs.push_back('{1'b0, 8'h00, 8'h00, 8'h00, 8'hA5, 8'hA5});
    vecs.push_back('{1'b1, 8'h83, 8'h5A, 8'h00, 8'h00, 8'hA5});
    vecs.push_back('{1'b0, 8'h03, 8'h00, 8'h00, 8'h5A, 8'hA5});
    vecs.push_back('{1'b0, 8'h0F, 8'h00, 8'h3C, 8'h3C, 8'hA5});
    vecs.push_back('{1'b1, 8'h8F, 8'hFF, 8'h3C, 8'h00, 8'hA5});
    vecs.push_back('{1'b0, 8'h0F, 8'h00, 8'h3C, 8'h3C, 8'hA5});
    vecs.push_back('{1'b0, 8'h30, 8'h00, 8'h3C, 8'h15, 8'hA5});
    vecs.push_back('{1'b0, 8'hB0, 8'h00, 8'h3C, 8'h15, 8'hA5});
    vecs.push_back('{1'b0, 8'h00, 8'h00, 8'h3C, 8'hA5, 8'hA5});
    vecs.push_back('{1'b1, 8'h82, 8'h77, 8'h3C, 8'h00, 8'hA5});
    vecs.push_back('{1'b0, 8'h02, 8'h00, 8'h3C, 8'h77, 8'hA5});
    vecs.push_back('{1'b1, 8'h8E, 8'h11, 8'h3C, 8'h00, 8'hA5});
    vecs.push_back('{1'b0, 8'h0E, 8'h00, 8'h3C, 8'h11, 8'hA5});
    vecs.push_back('{1'b0, 8'h7F, 8'h00, 8'h3C, 8'h15, 8'hA5});
    vecs.push_back('{1'b1, 8'h80, 8'hC3, 8'h3C, 8'h00, 8'hC3});
    vecs.push_back('{1'b0, 8'h0F, 8'h00, 8'h96, 8'h96, 8'hC3});
    vecs.push_back('{1'b0, 8'h01, 8'h00, 8'h96, 8'h00, 8'hC3});

    rst_n  = 1'b0;
    rx_stb = 1'b0;
    rx_dat = 8'h00;
    rx_err = 1'b0;
    tx_rdy = 1'b0;
    gpi    = 8'h00;

    // Reset values
    repeat (3) @(negedge clk);
    chk1("rst_rx_rdy", rx_rdy, 1'b0);
    chk1("rst_tx_stb", tx_stb, 1'b0);
    chk8("rst_tx_dat", tx_dat, 8'h00);
    chk8("rst_gpo", gpo, 8'h00);
    rst_n = 1'b1;
    #1 chk1("rel_rx_rdy_low", rx_rdy, 1'b0);
    @(negedge clk);
    chk1("rel_rx_rdy_high", rx_rdy, 1'b1);

    // Read held while transmitter busy
    send_byte(8'h03);
    for (int i = 0; i < 5; i++) begin
      chk1("hold_stb", tx_stb, 1'b1);
      chk8("hold_dat", tx_dat, 8'h00);
      chk1("hold_rxrdy", rx_rdy, 1'b0);
      @(negedge clk);
    end
    expect_resp("hold_end", 8'h00);

    // Transaction table
    foreach (vecs[i]) begin
      gpi = vecs[i].gpi;
      send_byte(vecs[i].cmd);
      if (vecs[i].two) begin
        send_byte(vecs[i].data);
        write_ack($sformatf("vec%0d_wr", i));
      end else begin
        expect_resp($sformatf("vec%0d_rd", i), vecs[i].exp_tx);
      end
      chk8($sformatf("vec%0d_gpo", i), gpo, vecs[i].exp_gpo);
    end

    // Timeout: byte arriving one cycle after the last allowed cycle is a new command
    send_byte(8'h82);
    repeat (TB_TO) @(negedge clk);
    send_byte(8'h02);
    expect_resp("timeout_rd", 8'h77);

    // Boundary: byte on the last allowed cycle is written
    send_byte(8'h82);
    repeat (TB_TO - 1) @(negedge clk);
    send_byte(8'h44);
    write_ack("boundary_wr");
    send_byte(8'h02);
    expect_resp("boundary_rd", 8'h44);

    // Error abort in DATA
    send_byte(8'h82);
    rx_err = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rx_err = 1'b0;
    send_byte(8'h02);
    expect_resp("err_rd", 8'h44);

    // Errored byte in IDLE is dropped
    rx_err = 1'b1;
    rx_stb = 1'b1;
    rx_dat = 8'h00;
    @(posedge clk);
    @(negedge clk);
    rx_stb = 1'b0;
    rx_err = 1'b0;
    expect_none("err_idle_drop");
    chk1("err_idle_rxrdy", rx_rdy, 1'b1);

    // Async reset while responding
    send_byte(8'h00);
    chk1("ares_pre_stb", tx_stb, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk1("ares_tx_stb", tx_stb, 1'b0);
    chk1("ares_rx_rdy", rx_rdy, 1'b0);
    chk8("ares_gpo", gpo, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int a = 0; a < 15; a++) begin
      send_byte(8'(a));
      expect_resp($sformatf("ares_reg%0d", a), 8'h00);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
